// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver (UART_RX_PARITY_EN adds PARITY state)
package uart_pkg;

    localparam int unsigned c_DATA_BITS              = 8;
    localparam logic        c_IDLE_LEVEL             = 1'b1;
    localparam int unsigned c_DEFAULT_CYCLES_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE,
        CLEANUP
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an idle-high asynchronous line
module sync_2ff (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_D,
    output logic o_Q
);

    logic meta;

    // Both flops come out of reset at the line's idle level so no false start is seen.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            meta <= 1'b1;
            o_Q  <= 1'b1;
        end else begin
            meta <= i_D;
            o_Q  <= meta;
        end
    end

endmodule

// File: rtl/uart_serial_rx.sv
// rtl/uart_serial_rx.sv - UART 8N1 receiver; define UART_RX_PARITY_EN for an even-parity bit and o_PARITY_ERROR
module uart_serial_rx
    import uart_pkg::*;
#(
    parameter int unsigned c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_SERIAL_DATA,
    output logic [7:0] o_DATA_RX,
    output logic       o_RX_DATA_VALID,
    output logic       o_RX_ACTIVE,
`ifdef UART_RX_PARITY_EN
    output logic       o_PARITY_ERROR,
`endif
    output logic       o_FRAME_ERROR
);

    localparam int unsigned c_CNT_W = $clog2(c_CYCLES_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_CNT = c_CNT_W'((c_CYCLES_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_BIT_CNT  = c_CNT_W'(c_CYCLES_PER_BIT - 1);
    localparam logic [2:0]         c_LAST_BIT = 3'(c_DATA_BITS - 1);

    uart_rx_state_t     state, state_nxt;
    logic [c_CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]         bit_idx, bit_idx_nxt;
    logic [7:0]         shift_q;
    logic               rx_sync;
    logic               data_sample;
    logic               stop_sample;
`ifdef UART_RX_PARITY_EN
    logic               par_sample;
    logic               par_q;
`endif

    sync_2ff u_sync (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .i_D     (i_SERIAL_DATA),
        .o_Q     (rx_sync)
    );

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Every exit from a timed state clears the cycle counter, so each phase starts from zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        data_sample = 1'b0;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (rx_sync != c_IDLE_LEVEL) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == c_HALF_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = (rx_sync == c_IDLE_LEVEL) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == c_BIT_CNT) begin
                    cnt_nxt     = '0;
                    data_sample = 1'b1;
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == c_BIT_CNT) begin
                    cnt_nxt    = '0;
                    par_sample = 1'b1;
                    state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == c_BIT_CNT) begin
                    cnt_nxt     = '0;
                    stop_sample = 1'b1;
                    state_nxt   = (rx_sync == c_IDLE_LEVEL) ? CLEANUP : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) is waited out before re-arming.
                cnt_nxt = '0;
                if (rx_sync == c_IDLE_LEVEL) begin
                    state_nxt = CLEANUP;
                end
            end
            CLEANUP: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            shift_q         <= '0;
            o_DATA_RX       <= '0;
            o_RX_DATA_VALID <= 1'b0;
            o_FRAME_ERROR   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q           <= 1'b0;
            o_PARITY_ERROR  <= 1'b0;
`endif
        end else begin
            o_RX_DATA_VALID <= 1'b0;
            o_FRAME_ERROR   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_PARITY_ERROR  <= 1'b0;
            if (par_sample) begin
                par_q <= rx_sync;
            end
`endif
            if (data_sample) begin
                shift_q[bit_idx] <= rx_sync;
            end
            if (stop_sample) begin
                if (rx_sync == c_IDLE_LEVEL) begin
`ifdef UART_RX_PARITY_EN
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if (^{shift_q, par_q}) begin
                        o_PARITY_ERROR <= 1'b1;
                    end else begin
                        o_DATA_RX       <= shift_q;
                        o_RX_DATA_VALID <= 1'b1;
                    end
`else
                    o_DATA_RX       <= shift_q;
                    o_RX_DATA_VALID <= 1'b1;
`endif
                end else begin
                    o_FRAME_ERROR <= 1'b1;
                end
            end
        end
    end

    assign o_RX_ACTIVE = (state != IDLE);

endmodule

// File: tb/tb_uart_serial_rx.sv
// tb/tb_uart_serial_rx.sv - self-checking bench for uart_serial_rx (honours UART_RX_PARITY_EN)
module tb_uart_serial_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // 3 cycles to start detect, half bit, remaining bits up to stop sample, 1 cycle register
    localparam int EXP_LAT = 3 + (CPB - 1) / 2 + 1 + (FRAME_BITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] data_rx;
    logic       valid;
    logic       active;
    logic       ferr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    uart_serial_rx #(.c_CYCLES_PER_BIT(CPB)) dut (
        .i_CLK           (clk),
        .i_RESET         (rst_n),
        .i_SERIAL_DATA   (rx_line),
        .o_DATA_RX       (data_rx),
        .o_RX_DATA_VALID (valid),
        .o_RX_ACTIVE     (active),
`ifdef UART_RX_PARITY_EN
        .o_PARITY_ERROR  (perr),
`endif
        .o_FRAME_ERROR   (ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         excl_viol = 0;
    int         act_run = 0;
    int         max_active = 0;
    int         last_valid_cyc = 0;
    int         fall_cyc = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_q.push_back(data_rx);
            last_valid_cyc = cyc;
        end
        if (ferr) ferr_cnt++;
        if (valid && ferr) excl_viol++;
`ifdef UART_RX_PARITY_EN
        if (perr) perr_cnt++;
        if (valid && perr) excl_viol++;
`endif
        if (active) act_run++;
        else act_run = 0;
        if (act_run > max_active) max_active = act_run;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_line = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input logic par_lvl);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_lvl);
`else
        if (par_lvl) begin end
`endif
        drive_bit(stop_lvl);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int v0, f0, q0, lat;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h5A, 1'b0, 8'hA5, 0, 1};
        vecs[2] = '{8'h96, 1'b1, 8'h96, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1, 0};
        vecs[4] = '{8'h7E, 1'b1, 8'h7E, 1, 0};

        idle(3);
        check("reset_data", int'(data_rx), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_active", int'(active), 0);
        check("reset_ferr", int'(ferr), 0);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
            if (!vecs[i].stop) begin
                idle(40);
                check($sformatf("vec%0d_active_while_low", i), int'(active), 1);
                check($sformatf("vec%0d_no_valid_while_low", i), valid_cnt - v0, 0);
                rx_line = 1'b1;
            end else begin
                lat = last_valid_cyc - fall_cyc;
                check($sformatf("vec%0d_latency_in_window", i),
                      int'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);
            end
            idle(2 * CPB);
            check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_data", i), int'(data_rx), int'(vecs[i].exp_data));
        end

        // back-to-back frames, no idle gap between stop and next start
        q0 = rx_q.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(2 * CPB);
        check("b2b_count", rx_q.size() - q0, 3);
        if (rx_q.size() - q0 == 3) begin
            check("b2b_byte0", int'(rx_q[q0]), 8'h00);
            check("b2b_byte1", int'(rx_q[q0 + 1]), 8'hFF);
            check("b2b_byte2", int'(rx_q[q0 + 2]), 8'h3C);
        end

        // short low glitch while idle
        v0 = valid_cnt;
        f0 = ferr_cnt;
        max_active = 0;
        rx_line = 1'b0;
        idle(4);
        rx_line = 1'b1;
        idle(2 * CPB);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_active_seen", int'(max_active >= 1), 1);
        check("glitch_active_le8", int'(max_active <= 8), 1);
        check("glitch_back_idle", int'(active), 0);

        // asynchronous reset in the middle of bit 4 of 8'hC3
        v0 = valid_cnt;
        f0 = ferr_cnt;
        begin
            logic [7:0] b;
            b = 8'hC3;
            drive_bit(1'b0);
            for (int i = 0; i < 4; i++) drive_bit(b[i]);
            rx_line = b[4];
            idle(CPB / 2);
        end
        check("midframe_active_before_reset", int'(active), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_data", int'(data_rx), 0);
        check("async_reset_active", int'(active), 0);
        check("async_reset_valid", int'(valid), 0);
        rx_line = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(2 * CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2 * CPB);
        check("post_reset_valid", valid_cnt - v0, 1);
        check("post_reset_ferr", ferr_cnt - f0, 0);
        check("post_reset_data", int'(data_rx), 8'h81);

`ifdef UART_RX_PARITY_EN
        v0 = valid_cnt;
        f0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * CPB);
        check("parity_bad_perr", perr_cnt - f0, 1);
        check("parity_bad_no_valid", valid_cnt - v0, 0);
        check("parity_bad_data_kept", int'(data_rx), 8'h81);
        v0 = valid_cnt;
        f0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * CPB);
        check("parity_good_valid", valid_cnt - v0, 1);
        check("parity_good_no_perr", perr_cnt - f0, 0);
        check("parity_good_data", int'(data_rx), 8'h07);
`endif

        check("valid_error_exclusive", excl_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
